// File: rtl/dsp_fetch_sequencer.sv
// dsp_fetch_sequencer: instruction fetch/issue stage for the DSP core.
// Sequences the PC, issues reads to the instruction memory bank, and buffers
// the responses in a first-word-fall-through prefetch FIFO that feeds decode.
// Redirects from the branch unit flush the FIFO and any in-flight response.
// Optional feature: define DSP_FETCH_HWLOOP_EN for the zero-overhead hardware loop.
//
// Decode handshake: instr_valid=1 means instr_out/instr_pc hold the FIFO head.
// The head is consumed on a cycle with instr_valid & instr_ready, unless
// jump_flag is also high, because a redirect voids that pop. While
// instr_valid & !instr_ready the head outputs do not change.
module dsp_fetch_sequencer #(
   parameter int                 IADDR_W    = 16,
   parameter int                 INSTR_W    = 32,
   parameter int                 FIFO_DEPTH = 4,
   parameter logic [IADDR_W-1:0] RESET_PC   = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_rd_en,
   output logic [IADDR_W-1:0] imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               jump_flag,
   input  logic [IADDR_W-1:0] jump_addr,
   input  logic               halt,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [IADDR_W-1:0] instr_pc,
`ifdef DSP_FETCH_HWLOOP_EN
   input  logic               loop_cfg,
   input  logic [IADDR_W-1:0] loop_start,
   input  logic [IADDR_W-1:0] loop_end,
   input  logic [15:0]        loop_count,
`endif
   output logic [1:0]         state_dbg
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IADDR_W-1:0] pc_q, pc_d;
   logic               inflight_q;
   logic [IADDR_W-1:0] inflight_pc_q;

   logic [INSTR_W-1:0] fifo_data [FIFO_DEPTH];
   logic [IADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;

   logic [CNT_W:0]     used;
   logic               credit_ok;
   logic               issue;
   logic               push;
   logic               pop;
   logic               loop_wrap;
   logic [IADDR_W-1:0] loop_target;

   // A read may only go out if its response is guaranteed a FIFO slot,
   // counting the response already on its way.
   assign used      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign credit_ok = used < (CNT_W+1)'(FIFO_DEPTH);

   // A redirect discards the response arriving this cycle and voids any pop.
   assign push = inflight_q & ~jump_flag;
   assign pop  = instr_valid & instr_ready & ~jump_flag;

`ifdef DSP_FETCH_HWLOOP_EN
   logic               loop_active_q;
   logic [IADDR_W-1:0] loop_start_q;
   logic [IADDR_W-1:0] loop_end_q;
   logic [15:0]        loop_rem_q;
   logic               loop_take;
   logic               loop_hit;

   assign loop_take   = loop_cfg & (state_q == ST_RUN) & ~jump_flag;
   assign loop_hit    = issue & loop_active_q & (pc_q == loop_end_q);
   assign loop_wrap   = loop_hit & (loop_rem_q > 16'd1);
   assign loop_target = loop_start_q;

   // Loop bookkeeping: a jump cancels the loop, config arms it, the last
   // pass through loop_end lets the PC fall through and disarms it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         loop_active_q <= 1'b0;
         loop_start_q  <= '0;
         loop_end_q    <= '0;
         loop_rem_q    <= '0;
      end else if (jump_flag) begin
         loop_active_q <= 1'b0;
      end else if (loop_take) begin
         loop_start_q  <= loop_start;
         loop_end_q    <= loop_end;
         loop_rem_q    <= loop_count;
         loop_active_q <= (loop_count != 16'd0);
      end else if (loop_hit) begin
         if (loop_rem_q > 16'd1) loop_rem_q <= loop_rem_q - 16'd1;
         else                    loop_active_q <= 1'b0;
      end
   end
`else
   assign loop_wrap   = 1'b0;
   assign loop_target = '0;
`endif

   // Next-state and issue decision; a jump always wins over issuing.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (jump_flag)  state_d = ST_FLUSH;
            else if (halt)  state_d = ST_HALT;
            else            issue   = credit_ok;
         end
         ST_FLUSH: begin
            if (jump_flag) begin
               state_d = ST_FLUSH;
            end else if (halt) begin
               state_d = ST_HALT;
            end else begin
               issue   = credit_ok;
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            if (!halt && !jump_flag) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      // No read strobe escapes while reset is held.
      if (!rst) issue = 1'b0;
   end

   // Next PC: redirect, loop wrap, or sequential increment on issue.
   always_comb begin
      pc_d = pc_q;
      if (jump_flag)      pc_d = jump_addr;
      else if (issue)     pc_d = loop_wrap ? loop_target : pc_q + IADDR_W'(1);
   end

   // State, PC and in-flight tracking registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= issue;
         if (issue) inflight_pc_q <= pc_q;
      end
   end

   // Prefetch FIFO: pushes returning data with its PC, pops on handshake,
   // and empties completely on a redirect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else if (jump_flag) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr_q] <= imem_data;
            fifo_pc[wr_ptr_q]   <= inflight_pc_q;
            wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign imem_rd_en  = issue;
   assign imem_addr   = pc_q;
   assign instr_valid = (count_q != '0);
   assign instr_out   = fifo_data[rd_ptr_q];
   assign instr_pc    = fifo_pc[rd_ptr_q];
   assign state_dbg   = state_q;

endmodule
